rom_read_arbiter: RTL and testbench

- Shares the single-port bitmap ROM (`rom_bmp`, 1-cycle read) between two pixel-domain requesters.
- Port 0 is the video display layer and is latency-critical. Port 1 is an overlay or background fetcher.
- Port 0 has fixed priority. A starvation guard bounds how long port 1 can wait.
- Read data is returned to the owning port with a valid strobe. The block also keeps a conflict statistics counter.

---
 rtl/rom_read_arbiter.sv | 107 ++++++++++
 tb/tb_rom_read_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// Two-port read arbiter in front of a single-port bitmap ROM: fixed priority to the
// display port, with a starvation guard for the overlay port and a conflict counter.
module rom_read_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 6,
    parameter int ROM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              pixel_clk,
    input  logic              sys_rst,

    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              valid0,
    output logic [DATA_W-1:0] data0,

    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              valid1,
    output logic [DATA_W-1:0] data1,

    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,

    input  logic              clr_stats,
    output logic [15:0]       conflict_cnt
);

    // One cycle to register the address, then the ROM's own latency.
    localparam int         LAT   = 1 + ROM_LATENCY;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [LAT-1:0]    vld_q, vld_d;
    logic [LAT-1:0]    id_q, id_d;
    logic [7:0]        wait1_q, wait1_d;
    logic [15:0]       cnt_q, cnt_d;

    logic force1;
    logic gnt_any;

    // Grants are suppressed during reset so nothing enters the pipeline.
    always_comb begin
        force1  = req1 && (wait1_q == LIMIT);
        gnt1    = !sys_rst && req1 && (!req0 || force1);
        gnt0    = !sys_rst && req0 && !gnt1;
        gnt_any = gnt0 || gnt1;
    end

    always_comb begin
        rom_addr_d = rom_addr_q;
        if (gnt1)
            rom_addr_d = addr1;
        else if (gnt0)
            rom_addr_d = addr0;
    end

    // Tag pipeline tracks which port owns the word arriving on rom_data.
    always_comb begin
        vld_d = {vld_q[LAT-2:0], gnt_any};
        id_d  = {id_q[LAT-2:0], gnt1};
    end

    always_comb begin
        wait1_d = wait1_q;
        if (gnt1 || !req1)
            wait1_d = 8'd0;
        else if (wait1_q < LIMIT)
            wait1_d = wait1_q + 8'd1;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_stats)
            cnt_d = 16'd0;
        else if (req0 && req1 && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            rom_addr_q <= '0;
            vld_q      <= '0;
            id_q       <= '0;
            wait1_q    <= 8'd0;
            cnt_q      <= 16'd0;
        end else begin
            rom_addr_q <= rom_addr_d;
            vld_q      <= vld_d;
            id_q       <= id_d;
            wait1_q    <= wait1_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        valid0       = !sys_rst && vld_q[LAT-1] && !id_q[LAT-1];
        valid1       = !sys_rst && vld_q[LAT-1] &&  id_q[LAT-1];
        data0        = rom_data;
        data1        = rom_data;
        rom_addr     = rom_addr_q;
        conflict_cnt = cnt_q;
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench: instance A (latency 1, starve limit 4) and instance B (latency 3).
module tb_rom_read_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic sys_rst;

    logic        a_req0, a_req1, a_gnt0, a_gnt1, a_valid0, a_valid1, a_clr;
    logic [14:0] a_addr0, a_addr1, a_rom_addr;
    logic [5:0]  a_data0, a_data1, a_rom_data;
    logic [15:0] a_cnt;

    logic        b_req0, b_req1, b_gnt0, b_gnt1, b_valid0, b_valid1, b_clr;
    logic [14:0] b_addr0, b_addr1, b_rom_addr;
    logic [5:0]  b_data0, b_data1, b_rom_data;
    logic [15:0] b_cnt;

    rom_read_arbiter #(.ROM_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
        .pixel_clk(clk), .sys_rst(sys_rst),
        .req0(a_req0), .addr0(a_addr0), .gnt0(a_gnt0), .valid0(a_valid0), .data0(a_data0),
        .req1(a_req1), .addr1(a_addr1), .gnt1(a_gnt1), .valid1(a_valid1), .data1(a_data1),
        .rom_addr(a_rom_addr), .rom_data(a_rom_data),
        .clr_stats(a_clr), .conflict_cnt(a_cnt)
    );

    rom_read_arbiter #(.ROM_LATENCY(3)) dut_b (
        .pixel_clk(clk), .sys_rst(sys_rst),
        .req0(b_req0), .addr0(b_addr0), .gnt0(b_gnt0), .valid0(b_valid0), .data0(b_data0),
        .req1(b_req1), .addr1(b_addr1), .gnt1(b_gnt1), .valid1(b_valid1), .data1(b_data1),
        .rom_addr(b_rom_addr), .rom_data(b_rom_data),
        .clr_stats(b_clr), .conflict_cnt(b_cnt)
    );

    function automatic logic [5:0] rom_f(input logic [14:0] a);
        return a[5:0] ^ a[11:6] ^ {3'b000, a[14:12]};
    endfunction

    // ROM models: ROM_LATENCY register stages between rom_addr and rom_data.
    logic [14:0] a_pipe;
    logic [14:0] b_pipe [3];
    always @(posedge clk) begin
        a_pipe    <= a_rom_addr;
        b_pipe[0] <= b_rom_addr;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_rom_data = rom_f(a_pipe);
    assign b_rom_data = rom_f(b_pipe[2]);

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [14:0] b_tbl [4];
    bit          exp_g1;

    initial begin
        sys_rst = 1'b1;
        a_req0 = 0; a_req1 = 0; a_addr0 = '0; a_addr1 = '0; a_clr = 0;
        b_req0 = 0; b_req1 = 0; b_addr0 = '0; b_addr1 = '0; b_clr = 0;
        b_tbl[0] = 15'h0011; b_tbl[1] = 15'h0222; b_tbl[2] = 15'h3333; b_tbl[3] = 15'h4444;

        // Reset state, with a request pending to confirm grants are blocked
        step(); step();
        a_req0 = 1; a_addr0 = 15'h0055;
        #1;
        chk("rst_gnt0", a_gnt0, 0);
        chk("rst_gnt1", a_gnt1, 0);
        chk("rst_valid0", a_valid0, 0);
        chk("rst_rom_addr", a_rom_addr, 0);
        chk("rst_cnt", a_cnt, 0);
        a_req0 = 0;
        step();
        sys_rst = 1'b0;
        step(); step();

        // Port 0 only
        a_req0 = 1; a_addr0 = 15'h0123;
        #1;
        chk("p0_gnt0", a_gnt0, 1);
        chk("p0_gnt1", a_gnt1, 0);
        step();
        a_req0 = 0;
        chk("p0_rom_addr", a_rom_addr, 15'h0123);
        chk("p0_valid0_early", a_valid0, 0);
        step();
        chk("p0_valid0", a_valid0, 1);
        chk("p0_data0", a_data0, rom_f(15'h0123));
        chk("p0_valid1", a_valid1, 0);
        step();
        chk("p0_valid0_done", a_valid0, 0);

        // Simultaneous single-cycle requests
        a_req0 = 1; a_addr0 = 15'd5; a_req1 = 1; a_addr1 = 15'd9;
        #1;
        chk("sim_c0_gnt0", a_gnt0, 1);
        chk("sim_c0_gnt1", a_gnt1, 0);
        step();
        a_req0 = 0;
        #1;
        chk("sim_c1_gnt1", a_gnt1, 1);
        chk("sim_c1_gnt0", a_gnt0, 0);
        chk("sim_c1_rom_addr", a_rom_addr, 15'd5);
        chk("sim_cnt", a_cnt, 1);
        step();
        a_req1 = 0;
        chk("sim_c2_valid0", a_valid0, 1);
        chk("sim_c2_data0", a_data0, rom_f(15'd5));
        chk("sim_c2_rom_addr", a_rom_addr, 15'd9);
        step();
        chk("sim_c3_valid1", a_valid1, 1);
        chk("sim_c3_data1", a_data1, rom_f(15'd9));
        chk("sim_c3_valid0", a_valid0, 0);
        chk("sim_c3_cnt", a_cnt, 1);
        step();

        // Withdrawn port-1 request leaves no starvation credit behind
        a_req0 = 1; a_req1 = 1;
        step(); step(); step();
        a_req1 = 0;
        step();
        a_req1 = 1; a_addr0 = 15'h0100; a_addr1 = 15'h0200;

        // Starvation with limit 4: port 1 wins every 5th cycle
        for (int k = 0; k < 15; k++) begin
            #1;
            exp_g1 = (k % 5) == 4;
            chk($sformatf("starve_gnt1_%0d", k), a_gnt1, exp_g1);
            chk($sformatf("starve_gnt0_%0d", k), a_gnt0, !exp_g1);
            step();
        end
        a_req0 = 0; a_req1 = 0;
        step(); step(); step();

        // Reset mid-flight
        a_req0 = 1; a_addr0 = 15'h0077;
        #1;
        chk("mid_gnt0", a_gnt0, 1);
        step();
        sys_rst = 1'b1;
        #1;
        chk("mid_rst_gnt0", a_gnt0, 0);
        chk("mid_rst_valid0", a_valid0, 0);
        chk("mid_rst_valid1", a_valid1, 0);
        step();
        sys_rst = 1'b0; a_req0 = 0;
        chk("mid_t2_valid0", a_valid0, 0);
        chk("mid_t2_rom_addr", a_rom_addr, 0);
        chk("mid_t2_cnt", a_cnt, 0);
        step();
        chk("mid_t3_valid0", a_valid0, 0);
        chk("mid_t3_valid1", a_valid1, 0);

        // Conflict counter saturation and clear
        a_req0 = 1; a_req1 = 1;
        for (int k = 0; k < 70000; k++) step();
        chk("sat_cnt", a_cnt, 16'hFFFF);
        step(); step(); step();
        chk("sat_hold", a_cnt, 16'hFFFF);
        a_clr = 1;
        step();
        a_clr = 0;
        chk("clr_cnt", a_cnt, 0);
        step();
        chk("clr_resume", a_cnt, 1);
        a_req0 = 0; a_req1 = 0;
        step(); step(); step();

        // Latency-3 instance: alternating single grants 0,1,0,1
        for (int c = 0; c < 10; c++) begin
            b_req0 = 0; b_req1 = 0;
            if (c < 4) begin
                if (c % 2 == 0) begin b_req0 = 1; b_addr0 = b_tbl[c]; end
                else            begin b_req1 = 1; b_addr1 = b_tbl[c]; end
            end
            #1;
            chk($sformatf("l3_gnt0_%0d", c), b_gnt0, (c < 4) && (c % 2 == 0));
            chk($sformatf("l3_gnt1_%0d", c), b_gnt1, (c < 4) && (c % 2 == 1));
            chk($sformatf("l3_valid0_%0d", c), b_valid0, (c >= 4) && (c < 8) && (c % 2 == 0));
            chk($sformatf("l3_valid1_%0d", c), b_valid1, (c >= 4) && (c < 8) && (c % 2 == 1));
            if (c >= 4 && c < 8) begin
                if (c % 2 == 0) chk($sformatf("l3_data0_%0d", c), b_data0, rom_f(b_tbl[c-4]));
                else            chk($sformatf("l3_data1_%0d", c), b_data1, rom_f(b_tbl[c-4]));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
